// File: rtl/res_station_bank_if.sv
// Issue, broadcast, branch-resolution and dispatch signals of one reservation-station bank.
// The bank drives the slave side; the issue/CDB/FU environment drives the master side.
interface res_station_bank_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   parameter int OP_W  = 6
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             write_i;
   logic [OP_W-1:0]  op_i;
   logic [TAG_W-1:0] tag1_i;
   logic [TAG_W-1:0] tag2_i;
   logic [WIDTH-1:0] value1_i;
   logic [WIDTH-1:0] value2_i;
   logic             spec_i;
   logic             full_o;
   logic [TAG_W-1:0] alloc_tag_o;
   logic [CNT_W-1:0] count_o;
   logic             cdb_valid_i;
   logic [TAG_W-1:0] cdb_tag_i;
   logic [WIDTH-1:0] cdb_val_i;
   logic             cond_eval_i;
   logic             corr_pred_i;
   logic             fu_valid_o;
   logic             fu_ready_i;
   logic [OP_W-1:0]  fu_op_o;
   logic [WIDTH-1:0] fu_val1_o;
   logic [WIDTH-1:0] fu_val2_o;
   logic [TAG_W-1:0] fu_tag_o;

   modport master (
      output write_i, op_i, tag1_i, tag2_i, value1_i, value2_i, spec_i,
      output cdb_valid_i, cdb_tag_i, cdb_val_i, cond_eval_i, corr_pred_i, fu_ready_i,
      input  full_o, alloc_tag_o, count_o,
      input  fu_valid_o, fu_op_o, fu_val1_o, fu_val2_o, fu_tag_o
   );

   modport slave (
      input  write_i, op_i, tag1_i, tag2_i, value1_i, value2_i, spec_i,
      input  cdb_valid_i, cdb_tag_i, cdb_val_i, cond_eval_i, corr_pred_i, fu_ready_i,
      output full_o, alloc_tag_o, count_o,
      output fu_valid_o, fu_op_o, fu_val1_o, fu_val2_o, fu_tag_o
   );
endinterface

// File: rtl/res_station_bank.sv
// Reservation-station bank: entries wait for CDB operands, oldest ready entry goes to the FU.
// Dispatch earliest one cycle after write/capture; presented entry holds while fu_ready_i=0, write ignored when full.
module res_station_bank #(
   parameter int DEPTH    = 4,
   parameter int WIDTH    = 32,
   parameter int TAG_W    = 4,
   parameter int OP_W     = 6,
   parameter int BASE_TAG = 1
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   res_station_bank_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic             busy;
      logic             spec;
      logic [OP_W-1:0]  op;
      logic [TAG_W-1:0] tag1;
      logic [TAG_W-1:0] tag2;
      logic [WIDTH-1:0] val1;
      logic [WIDTH-1:0] val2;
   } entry_t;

   entry_t           ent_q   [DEPTH];
   entry_t           ent_d   [DEPTH];
   // older_q[i][j] set: entry i was written before entry j
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] older_d [DEPTH];

   logic [DEPTH-1:0] busy_vec;
   logic [DEPTH-1:0] rdy_vec;
   logic [DEPTH-1:0] is_oldest;
   logic             full;
   logic [IDX_W-1:0] alloc_idx;
   logic [CNT_W-1:0] occ;
   logic             any_rdy;
   logic [IDX_W-1:0] sel_idx;
   logic             flush;
   logic             resolve_ok;
   logic             wr_acc;
   logic             deq;
   logic             cdb_hit;
   logic             byp1;
   logic             byp2;

   always_comb begin
      busy_vec = '0;
      rdy_vec  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_vec[i] = ent_q[i].busy;
         rdy_vec[i]  = ent_q[i].busy && (ent_q[i].tag1 == '0) &&
                       (ent_q[i].tag2 == '0) && !ent_q[i].spec;
      end
   end

   always_comb begin
      alloc_idx = '0;
      occ       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy_vec[i]) alloc_idx = IDX_W'(i);
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (busy_vec[i]) occ = occ + CNT_W'(1);
      end
   end

   assign full = &busy_vec;

   // Age is a total order over busy entries, so exactly one ready entry survives this filter.
   always_comb begin
      is_oldest = '0;
      any_rdy   = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         is_oldest[i] = rdy_vec[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && rdy_vec[j] && !older_q[i][j]) is_oldest[i] = 1'b0;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (is_oldest[i]) begin
            any_rdy = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
   end

   assign flush      = bus.cond_eval_i & ~bus.corr_pred_i;
   assign resolve_ok = bus.cond_eval_i & bus.corr_pred_i;
   assign wr_acc     = bus.write_i & ~full & ~(flush & bus.spec_i);
   assign deq        = any_rdy & bus.fu_ready_i;
   assign cdb_hit    = bus.cdb_valid_i && (bus.cdb_tag_i != '0);
   assign byp1       = cdb_hit && (bus.tag1_i == bus.cdb_tag_i);
   assign byp2       = cdb_hit && (bus.tag2_i == bus.cdb_tag_i);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i]   = ent_q[i];
         older_d[i] = older_q[i];
         if (ent_q[i].busy) begin
            if (cdb_hit && ent_q[i].tag1 == bus.cdb_tag_i) begin
               ent_d[i].tag1 = '0;
               ent_d[i].val1 = bus.cdb_val_i;
            end
            if (cdb_hit && ent_q[i].tag2 == bus.cdb_tag_i) begin
               ent_d[i].tag2 = '0;
               ent_d[i].val2 = bus.cdb_val_i;
            end
            if (resolve_ok) ent_d[i].spec = 1'b0;
            if (flush && ent_q[i].spec) ent_d[i].busy = 1'b0;
            if (deq && sel_idx == IDX_W'(i)) ent_d[i].busy = 1'b0;
         end
         if (wr_acc && alloc_idx == IDX_W'(i)) begin
            ent_d[i].busy = 1'b1;
            ent_d[i].spec = bus.spec_i & ~resolve_ok;
            ent_d[i].op   = bus.op_i;
            ent_d[i].tag1 = byp1 ? '0 : bus.tag1_i;
            ent_d[i].val1 = byp1 ? bus.cdb_val_i : bus.value1_i;
            ent_d[i].tag2 = byp2 ? '0 : bus.tag2_i;
            ent_d[i].val2 = byp2 ? bus.cdb_val_i : bus.value2_i;
         end
      end
      // New entry becomes the youngest; stale bits of free entries are rewritten on their own allocation.
      if (wr_acc) begin
         for (int j = 0; j < DEPTH; j++) begin
            older_d[alloc_idx][j] = 1'b0;
            older_d[j][alloc_idx] = (j != int'(alloc_idx));
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i]   <= '0;
            older_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i]   <= ent_d[i];
            older_q[i] <= older_d[i];
         end
      end
   end

   assign bus.full_o      = full;
   assign bus.alloc_tag_o = full ? '0 : TAG_W'(BASE_TAG + int'(alloc_idx));
   assign bus.count_o     = occ;
   assign bus.fu_valid_o  = any_rdy;
   assign bus.fu_op_o     = any_rdy ? ent_q[sel_idx].op   : '0;
   assign bus.fu_val1_o   = any_rdy ? ent_q[sel_idx].val1 : '0;
   assign bus.fu_val2_o   = any_rdy ? ent_q[sel_idx].val2 : '0;
   assign bus.fu_tag_o    = any_rdy ? TAG_W'(BASE_TAG + int'(sel_idx)) : '0;
endmodule

// File: tb/tb_res_station_bank.sv
// Bench for res_station_bank: directed vector table, reset corner cases, then random traffic against an age-ordered queue model.
module tb_res_station_bank;
   localparam int DEPTH = 4, WIDTH = 32, TAG_W = 4, OP_W = 6, BASE_TAG = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   res_station_bank_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

   res_station_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_W(TAG_W), .OP_W(OP_W), .BASE_TAG(BASE_TAG)) dut (
      .clk_i   (clk),
      .reset_ni(rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit wr, input logic [OP_W-1:0] op, input logic [TAG_W-1:0] t1, t2,
                        input logic [WIDTH-1:0] v1, v2, input bit sp, cv, input logic [TAG_W-1:0] ct,
                        input logic [WIDTH-1:0] cval, input bit ce, cp, rdy);
      bus.write_i     = wr;   bus.op_i        = op;
      bus.tag1_i      = t1;   bus.tag2_i      = t2;
      bus.value1_i    = v1;   bus.value2_i    = v2;
      bus.spec_i      = sp;   bus.cdb_valid_i = cv;
      bus.cdb_tag_i   = ct;   bus.cdb_val_i   = cval;
      bus.cond_eval_i = ce;   bus.corr_pred_i = cp;
      bus.fu_ready_i  = rdy;
   endtask

   task automatic idle();
      drive(0, '0, '0, '0, '0, '0, 0, 0, '0, '0, 0, 0, 0);
   endtask

   // One row = inputs held across one edge, then outputs expected just after it.
   typedef struct {
      bit wr; logic [31:0] v1; logic [3:0] t1, t2; bit sp, cv; logic [3:0] ct; logic [31:0] cval;
      bit ce, cp, rdy;
      bit e_full; logic [3:0] e_atag; logic [2:0] e_cnt; bit e_vld; logic [3:0] e_ftag;
      logic [31:0] e_v1, e_v2;
   } vec_t;
   vec_t vq[$];

   function automatic void add(bit wr, logic [31:0] v1, logic [3:0] t1, t2, bit sp, cv, logic [3:0] ct,
                               logic [31:0] cval, bit ce, cp, rdy, bit e_full, logic [3:0] e_atag,
                               logic [2:0] e_cnt, bit e_vld, logic [3:0] e_ftag, logic [31:0] e_v1, e_v2);
      vec_t v;
      v.wr = wr; v.v1 = v1; v.t1 = t1; v.t2 = t2; v.sp = sp; v.cv = cv; v.ct = ct; v.cval = cval;
      v.ce = ce; v.cp = cp; v.rdy = rdy; v.e_full = e_full; v.e_atag = e_atag; v.e_cnt = e_cnt;
      v.e_vld = e_vld; v.e_ftag = e_ftag; v.e_v1 = e_v1; v.e_v2 = e_v2;
      vq.push_back(v);
   endfunction

   // Reference model: busy entries kept in a queue ordered oldest first.
   typedef struct {
      int slot; logic [OP_W-1:0] op; logic [TAG_W-1:0] t1, t2; logic [WIDTH-1:0] v1, v2; bit spec;
   } m_ent_t;
   m_ent_t mq[$];

   function automatic int m_free();
      bit used [DEPTH];
      for (int s = 0; s < DEPTH; s++) used[s] = 0;
      foreach (mq[k]) used[mq[k].slot] = 1;
      for (int s = 0; s < DEPTH; s++) if (!used[s]) return s;
      return -1;
   endfunction

   function automatic int m_ready();
      foreach (mq[k]) if (mq[k].t1 == 0 && mq[k].t2 == 0 && !mq[k].spec) return k;
      return -1;
   endfunction

   task automatic model_check(input int cyc);
      int f, r;
      f = m_free();
      r = m_ready();
      chk($sformatf("rnd%0d.full", cyc), 32'(bus.full_o), 32'(mq.size() == DEPTH));
      chk($sformatf("rnd%0d.alloc_tag", cyc), 32'(bus.alloc_tag_o), (f < 0) ? 32'd0 : 32'(BASE_TAG + f));
      chk($sformatf("rnd%0d.count", cyc), 32'(bus.count_o), 32'(mq.size()));
      chk($sformatf("rnd%0d.fu_valid", cyc), 32'(bus.fu_valid_o), 32'(r >= 0));
      if (r >= 0) begin
         chk($sformatf("rnd%0d.fu_op", cyc), 32'(bus.fu_op_o), 32'(mq[r].op));
         chk($sformatf("rnd%0d.fu_tag", cyc), 32'(bus.fu_tag_o), 32'(BASE_TAG + mq[r].slot));
         chk($sformatf("rnd%0d.fu_val1", cyc), bus.fu_val1_o, mq[r].v1);
         chk($sformatf("rnd%0d.fu_val2", cyc), bus.fu_val2_o, mq[r].v2);
      end
   endtask

   task automatic model_step(input bit wr, input logic [OP_W-1:0] op, input logic [TAG_W-1:0] t1, t2,
                             input logic [WIDTH-1:0] v1, v2, input bit sp, cv, input logic [TAG_W-1:0] ct,
                             input logic [WIDTH-1:0] cval, input bit ce, cp, rdy);
      int f, r, n;
      m_ent_t nq[$];
      m_ent_t e;
      f = m_free();
      r = m_ready();
      n = mq.size();
      for (int k = 0; k < n; k++) begin
         if (k == r && rdy) continue;
         if (ce && !cp && mq[k].spec) continue;
         e = mq[k];
         if (ce && cp) e.spec = 0;
         if (cv && ct != 0) begin
            if (e.t1 == ct) begin e.t1 = 0; e.v1 = cval; end
            if (e.t2 == ct) begin e.t2 = 0; e.v2 = cval; end
         end
         nq.push_back(e);
      end
      if (wr && n < DEPTH && !(ce && !cp && sp)) begin
         e.slot = f; e.op = op; e.spec = sp && !(ce && cp);
         e.t1 = t1; e.v1 = v1; e.t2 = t2; e.v2 = v2;
         if (cv && ct != 0 && t1 == ct) begin e.t1 = 0; e.v1 = cval; end
         if (cv && ct != 0 && t2 == ct) begin e.t2 = 0; e.v2 = cval; end
         nq.push_back(e);
      end
      mq = nq;
   endtask

   initial begin
      idle();
      #1 rst_n = 1'b0;
      #1;
      chk("rst.full", 32'(bus.full_o), 32'd0);
      chk("rst.count", 32'(bus.count_o), 32'd0);
      chk("rst.fu_valid", 32'(bus.fu_valid_o), 32'd0);
      chk("rst.alloc_tag", 32'(bus.alloc_tag_o), 32'(BASE_TAG));
      chk("rst.fu_op", 32'(bus.fu_op_o), 32'd0);
      chk("rst.fu_val1", bus.fu_val1_o, 32'd0);
      chk("rst.fu_tag", 32'(bus.fu_tag_o), 32'd0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      //   wr v1     t1 t2 sp cv ct cval  ce cp rdy | full atag cnt vld ftag ev1    ev2
      add(1, 10,    0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 2, 1, 1, 1, 10,    20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 0, 0, 0, 0,     0);
      add(1, 100,   0, 0, 0, 0, 0, 0,    0, 0, 0,  0, 2, 1, 1, 1, 100,   20);
      add(1, 101,   0, 0, 0, 0, 0, 0,    0, 0, 0,  0, 3, 2, 1, 1, 100,   20);
      add(1, 102,   0, 0, 0, 0, 0, 0,    0, 0, 0,  0, 4, 3, 1, 1, 100,   20);
      add(1, 103,   0, 0, 0, 0, 0, 0,    0, 0, 0,  1, 0, 4, 1, 1, 100,   20);
      add(1, 999,   0, 0, 0, 0, 0, 0,    0, 0, 0,  1, 0, 4, 1, 1, 100,   20);
      add(1, 998,   0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 3, 1, 2, 101,   20);
      add(1, 200,   0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 2, 3, 1, 3, 102,   20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 2, 2, 1, 4, 103,   20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 2, 1, 1, 1, 200,   20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 0, 0, 0, 0,     0);
      add(1, 300,   0, 0, 0, 0, 0, 0,    0, 0, 0,  0, 2, 1, 1, 1, 300,   20);
      add(1, 301,   7, 0, 0, 0, 0, 0,    0, 0, 0,  0, 3, 2, 1, 1, 300,   20);
      add(1, 302,   8, 0, 0, 0, 0, 0,    0, 0, 0,  0, 4, 3, 1, 1, 300,   20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 2, 0, 0, 0,     0);
      add(1, 303,   8, 0, 0, 0, 0, 0,    0, 0, 0,  0, 4, 3, 0, 0, 0,     0);
      add(0, 0,     0, 0, 0, 1, 8, 'h88, 0, 0, 0,  0, 4, 3, 1, 3, 'h88,  20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 3, 2, 1, 1, 'h88,  20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 1, 0, 0, 0,     0);
      add(0, 0,     0, 0, 0, 1, 7, 'h77, 0, 0, 0,  0, 1, 1, 1, 2, 'h77,  20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 0, 0, 0, 0,     0);
      add(1, 5,     7, 0, 0, 1, 7, 'hAB, 0, 0, 0,  0, 2, 1, 1, 1, 'hAB,  20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 0, 0, 0, 0,     0);
      add(1, 1,     3, 3, 0, 1, 0, 'h55, 0, 0, 0,  0, 2, 1, 0, 0, 0,     0);
      add(0, 0,     0, 0, 0, 1, 3, 'h33, 0, 0, 0,  0, 2, 1, 1, 1, 'h33,  'h33);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 0, 0, 0, 0,     0);
      add(1, 'h501, 0, 0, 1, 0, 0, 0,    0, 0, 0,  0, 2, 1, 0, 0, 0,     0);
      add(1, 'h502, 0, 0, 1, 0, 0, 0,    0, 0, 0,  0, 3, 2, 0, 0, 0,     0);
      add(1, 'h503, 0, 0, 0, 0, 0, 0,    0, 0, 0,  0, 4, 3, 1, 3, 'h503, 20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    1, 0, 0,  0, 1, 1, 1, 3, 'h503, 20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 0, 0, 0, 0,     0);
      add(1, 'h501, 0, 0, 1, 0, 0, 0,    0, 0, 0,  0, 2, 1, 0, 0, 0,     0);
      add(1, 'h502, 0, 0, 1, 0, 0, 0,    0, 0, 0,  0, 3, 2, 0, 0, 0,     0);
      add(1, 'h503, 0, 0, 0, 0, 0, 0,    0, 0, 0,  0, 4, 3, 1, 3, 'h503, 20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    1, 1, 0,  0, 4, 3, 1, 1, 'h501, 20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 2, 1, 2, 'h502, 20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 1, 1, 3, 'h503, 20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 0, 0, 0, 0,     0);
      add(1, 'h600, 0, 0, 1, 0, 0, 0,    1, 0, 0,  0, 1, 0, 0, 0, 0,     0);
      add(1, 'h601, 0, 0, 1, 0, 0, 0,    1, 1, 0,  0, 2, 1, 1, 1, 'h601, 20);
      add(0, 0,     0, 0, 0, 0, 0, 0,    0, 0, 1,  0, 1, 0, 0, 0, 0,     0);

      foreach (vq[k]) begin
         drive(vq[k].wr, 6'd5, vq[k].t1, vq[k].t2, vq[k].v1, 32'd20, vq[k].sp, vq[k].cv,
               vq[k].ct, vq[k].cval, vq[k].ce, vq[k].cp, vq[k].rdy);
         @(posedge clk); #1;
         chk($sformatf("v%0d.full", k), 32'(bus.full_o), 32'(vq[k].e_full));
         chk($sformatf("v%0d.alloc_tag", k), 32'(bus.alloc_tag_o), 32'(vq[k].e_atag));
         chk($sformatf("v%0d.count", k), 32'(bus.count_o), 32'(vq[k].e_cnt));
         chk($sformatf("v%0d.fu_valid", k), 32'(bus.fu_valid_o), 32'(vq[k].e_vld));
         if (vq[k].e_vld) begin
            chk($sformatf("v%0d.fu_tag", k), 32'(bus.fu_tag_o), 32'(vq[k].e_ftag));
            chk($sformatf("v%0d.fu_val1", k), bus.fu_val1_o, vq[k].e_v1);
            chk($sformatf("v%0d.fu_val2", k), bus.fu_val2_o, vq[k].e_v2);
         end
      end

      // Asynchronous reset mid-cycle with three ready entries, then no dispatch after release.
      for (int k = 0; k < 3; k++) begin
         drive(1, 6'd9, '0, '0, 32'(k + 1), 32'd7, 0, 0, '0, '0, 0, 0, 0);
         @(posedge clk); #1;
      end
      idle();
      chk("pre_rst.count", 32'(bus.count_o), 32'd3);
      chk("pre_rst.fu_valid", 32'(bus.fu_valid_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst.count", 32'(bus.count_o), 32'd0);
      chk("mid_rst.full", 32'(bus.full_o), 32'd0);
      chk("mid_rst.fu_valid", 32'(bus.fu_valid_o), 32'd0);
      chk("mid_rst.alloc_tag", 32'(bus.alloc_tag_o), 32'(BASE_TAG));
      chk("mid_rst.fu_op", 32'(bus.fu_op_o), 32'd0);
      chk("mid_rst.fu_val1", bus.fu_val1_o, 32'd0);
      chk("mid_rst.fu_val2", bus.fu_val2_o, 32'd0);
      chk("mid_rst.fu_tag", 32'(bus.fu_tag_o), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      bus.fu_ready_i = 1'b1;
      @(posedge clk); #1;
      chk("post_rst.fu_valid", 32'(bus.fu_valid_o), 32'd0);
      chk("post_rst.count", 32'(bus.count_o), 32'd0);

      // Random traffic against the queue model.
      mq.delete();
      for (int c = 0; c < 3000; c++) begin
         bit wr, sp, cv, ce, cp, rdy;
         logic [OP_W-1:0] op;
         logic [TAG_W-1:0] t1, t2, ct;
         logic [WIDTH-1:0] v1, v2, cval;
         model_check(c);
         wr   = ($urandom_range(0, 2) != 0);
         op   = OP_W'($urandom);
         t1   = ($urandom_range(0, 9) < 3) ? TAG_W'($urandom_range(1, 15)) : '0;
         t2   = ($urandom_range(0, 9) < 3) ? TAG_W'($urandom_range(1, 15)) : '0;
         v1   = $urandom;
         v2   = $urandom;
         sp   = ($urandom_range(0, 3) == 0);
         cv   = $urandom_range(0, 1) == 1;
         ct   = TAG_W'($urandom_range(0, 15));
         cval = $urandom;
         ce   = ($urandom_range(0, 11) == 0);
         cp   = $urandom_range(0, 1) == 1;
         rdy  = $urandom_range(0, 1) == 1;
         drive(wr, op, t1, t2, v1, v2, sp, cv, ct, cval, ce, cp, rdy);
         model_step(wr, op, t1, t2, v1, v2, sp, cv, ct, cval, ce, cp, rdy);
         @(posedge clk); #1;
      end
      model_check(3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/res_station_bank.md
RES_STATION_BANK -- requirements
Module: res_station_bank

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH, 4, entry count (2..8).
- WIDTH, 32, operand width.
- TAG_W, 4, tag width; tag 0 = NO_VAL.
- OP_W, 6, opaque opcode width.
- BASE_TAG, 1, tag of entry 0; entry i owns BASE_TAG+i.

REQ-002 The block SHALL have these ports:
- clk_i  in  1  clock.
- reset_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- write_i  in  1  issue request.
- op_i  in  OP_W  opcode.
- tag1_i, tag2_i  in  TAG_W  source producer tags.
- value1_i, value2_i  in  WIDTH  source values.
- spec_i  in  1  issued instruction is speculative.
- full_o  out  1  no free entry.
- alloc_tag_o  out  TAG_W  tag that a write this cycle receives.
- count_o  out  $clog2(DEPTH+1)  occupied entries.
- cdb_valid_i  in  1  broadcast valid.
- cdb_tag_i  in  TAG_W  broadcast tag.
- cdb_val_i  in  WIDTH  broadcast value.
- cond_eval_i  in  1  branch resolved this cycle.
- corr_pred_i  in  1  prediction correct (qualified by cond_eval_i).
- fu_valid_o  out  1  dispatch valid.
- fu_ready_i  in  1  FU accepts.
- fu_op_o  out  OP_W  dispatched opcode.
- fu_val1_o, fu_val2_o  out  WIDTH  dispatched operands.
- fu_tag_o  out  TAG_W  dispatched entry tag.

Function
REQ-003 Each entry SHALL hold: busy, spec, op, tag1/2, val1/2, and an age relative to every other entry.
REQ-004 Allocation SHALL go to the lowest-index free entry; alloc_tag_o SHALL equal BASE_TAG+that index; full_o=1 and alloc_tag_o=0 when no entry is free.
REQ-005 write_i while full_o=1 SHALL be ignored with no state change.
REQ-006 full_o and count_o SHALL derive from registered state only. An entry freed this cycle SHALL NOT be reallocated until the next cycle.
REQ-007 A written entry SHALL be younger than every occupied entry.
REQ-008 CDB capture: for each busy entry, when cdb_valid_i=1, cdb_tag_i!=0 and cdb_tag_i==tagN, the entry SHALL set tagN<=0 and valN<=cdb_val_i. Both operands may capture in the same cycle.
REQ-009 Write bypass: on write, a source tag equal to cdb_tag_i with cdb_valid_i=1 SHALL be stored as tag 0 with value cdb_val_i instead of value*_i.
REQ-010 An entry SHALL be ready when busy=1, tag1=0, tag2=0 and spec=0, evaluated on registered state. Earliest dispatch is the cycle after the write or capture.
REQ-011 fu_valid_o SHALL be 1 iff any entry is ready. fu_* outputs SHALL present the oldest ready entry.
REQ-012 Entry release on dispatch: when fu_valid_o and fu_ready_i are both 1, the selected entry SHALL be freed at the clock edge.
REQ-013 Dispatch stability: while fu_valid_o=1 and fu_ready_i=0, the presented entry SHALL remain presented, unless an older entry becomes ready or a flush occurs.
REQ-014 Branch resolution, correct prediction: on cond_eval_i=1 with corr_pred_i=1, all spec bits SHALL clear.
REQ-015 Branch resolution, misprediction: on cond_eval_i=1 with corr_pred_i=0, all entries with spec=1 SHALL be freed. Non-speculative entries SHALL be unaffected.
REQ-016 A write in a resolution cycle with spec_i=1 SHALL be resolved with that branch: dropped on mispredict, stored with spec=0 if correct. It SHALL still consume the allocation only if kept.
REQ-017 count_o SHALL equal the number of busy entries. Simultaneous write, dispatch and flush SHALL update it by net change at the edge.

Reset
REQ-018 Assertion of reset_ni=0 SHALL immediately clear all busy, spec and tag fields and the age state, regardless of clock. Values and opcodes SHALL clear to 0.
REQ-019 During and after reset:
- full_o=0, count_o=0, fu_valid_o=0.
- alloc_tag_o=BASE_TAG.
- fu_op_o, fu_val*_o, fu_tag_o=0.
REQ-020 Reset mid-operation SHALL discard all entries. No dispatch SHALL occur in the cycle following deassertion.

Verification
REQ-021 Write op=5, tag1=0, tag2=0, val 10/20, fu_ready_i=1 -> next cycle fu_valid_o=1, fu_val1_o=10, fu_val2_o=20, fu_tag_o=1; following cycle count_o=0.
REQ-022 Write tag1=7; later CDB tag 7 val 0xAB -> fu_valid_o=1 one cycle after the broadcast, with fu_val1_o=0xAB. Repeat with the CDB in the write cycle -> dispatch the next cycle (bypass).
REQ-023 Fill 4 entries all ready with fu_ready_i=0 -> full_o=1, count_o=4; further write ignored. Then fu_ready_i=1 -> dispatch order equals write order; entry 0 is reallocated first.
REQ-024 Two speculative entries plus one normal entry, then cond_eval_i=1, corr_pred_i=0 -> count_o=1, only the normal entry dispatches. Repeat with corr_pred_i=1 -> all three dispatch.
REQ-025 Write in entry 2, then entry 0 is freed and rewritten, both become ready -> entry 2 (older) dispatches first despite the higher index.
REQ-026 Assert reset_ni=0 mid-cycle with 3 entries busy -> outputs clear before the next clock edge; count_o=0.
